// File: rtl/demux1ne2_reg.sv
// -----------------------------------------------------------------------------
// demux1ne2_reg : registered 1-to-2 demultiplexer with valid/ready handshakes.
//
// Steers one input stream to one of two output channels. The channel is
// chosen per transfer by sinjali. Each channel has a one-entry holding
// register, so the two consumers are decoupled from each other and from the
// producer. The input is blocked only by the channel it currently selects.
//
// Parameters
//   WIDTH  data width in bits (>= 1)
//   CNT_W  width of the per-channel completed-transfer counters
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   hyrja, sinjali        input word and channel select (0 -> dalja0, 1 -> dalja1)
//   in_valid, in_ready    input handshake; in_ready is 0 while rst_n = 0
//   dalja0, out0_valid,   channel 0 data/valid (both straight from flops)
//   out0_ready              and consumer ready
//   dalja1, out1_valid,   channel 1 data/valid (both straight from flops)
//   out1_ready              and consumer ready
//   cnt_clr               synchronous clear of both counters
//   cnt0, cnt1            completed output transfers per channel
//
// Configuration
//   DEMUX_CNT_EN  when defined, cnt0/cnt1 count completed output handshakes
//                 (modulo 2^CNT_W, cnt_clr wins over a same-cycle increment).
//                 When undefined, the counters are tied to 0, cnt_clr is
//                 ignored and the port list is unchanged.
// -----------------------------------------------------------------------------
module demux1ne2_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] hyrja,
  input  logic             sinjali,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dalja0,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] dalja1,
  output logic             out1_valid,
  input  logic             out1_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic sel_free;  // selected channel is empty or draining this cycle
  logic acc0;
  logic acc1;
  logic drain0;
  logic drain1;

  // Only the selected channel gates the input, so a stalled channel never
  // blocks traffic headed for the other one.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // unassigned; otherwise synthesis infers a latch.
    sel_free = 1'b0;
    if (sinjali) begin
      sel_free = ~out1_valid | out1_ready;
    end else begin
      sel_free = ~out0_valid | out0_ready;
    end
  end

  assign in_ready = rst_n & sel_free;

  assign acc0   = in_valid & in_ready & ~sinjali;
  assign acc1   = in_valid & in_ready &  sinjali;
  assign drain0 = out0_valid & out0_ready;
  assign drain1 = out1_valid & out1_ready;

  // Channel 0 holding register. An accept takes precedence over a drain: a
  // same-cycle drain + accept replaces the word and valid stays high, which
  // gives one word per cycle per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset as well because the outputs are
      // defined as 0 during reset, not merely "don't care while invalid".
      dalja0     <= '0;
      out0_valid <= 1'b0;
    end else if (acc0) begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // pre-edge values regardless of statement order.
      dalja0     <= hyrja;
      out0_valid <= 1'b1;
    end else if (drain0) begin
      out0_valid <= 1'b0;  // data keeps its last value
    end
  end

  // Channel 1 holding register, same rules as channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dalja1     <= '0;
      out1_valid <= 1'b0;
    end else if (acc1) begin
      dalja1     <= hyrja;
      out1_valid <= 1'b1;
    end else if (drain1) begin
      out1_valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  // Completed output transfers per channel; clear beats increment and the
  // counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (drain0) cnt0 <= cnt0 + CNT_W'(1);
      if (drain1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`else
  // Counters removed: outputs tied low, clear input deliberately sunk.
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule
